// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states and
// opcode classification helpers.
package md_defs;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MADD  = 4'd4;
  localparam logic [3:0] MD_MADDU = 4'd5;
  localparam logic [3:0] MD_MSUB  = 4'd6;
  localparam logic [3:0] MD_MSUBU = 4'd7;
  localparam logic [3:0] MD_MTHI  = 4'd8;
  localparam logic [3:0] MD_MTLO  = 4'd9;

  // Divide by zero fills the quotient (LO) with this bit; HI takes the dividend.
  localparam logic DIV0_QUOT_FILL = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Codes 0..7 go through the multi-cycle path.
  function automatic logic is_multi(input logic [3:0] op);
    return (op <= MD_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_compute.sv
// Combinational result generator: maps operands, current {hi,lo} and opcode
// to the 2*WIDTH value that {hi,lo} will take once the operation retires.
module md_compute
  import md_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] res
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [W2-1:0] sprod;
  logic        [W2-1:0] uprod;

  // Signed divide with zero-divisor and most-negative/-1 overflow handling;
  // returns {remainder, quotient}. SV '/' and '%' truncate toward zero.
  function automatic logic [W2-1:0] div_signed(input logic signed [WIDTH-1:0] n,
                                               input logic signed [WIDTH-1:0] d);
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] r;
    if (d == '0) return {n, {WIDTH{DIV0_QUOT_FILL}}};
    if ((n == MOST_NEG) && (d == '1)) return {{WIDTH{1'b0}}, MOST_NEG};
    q = n / d;
    r = n % d;
    return {r, q};
  endfunction

  // Unsigned divide; returns {remainder, quotient}.
  function automatic logic [W2-1:0] div_unsigned(input logic [WIDTH-1:0] n,
                                                 input logic [WIDTH-1:0] d);
    if (d == '0) return {n, {WIDTH{DIV0_QUOT_FILL}}};
    return {n % d, n / d};
  endfunction

  // Full-width products, operands extended to 2*WIDTH before multiplying.
  assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Opcode select; unlisted codes leave {hi,lo} as is.
  always_comb begin
    res = acc;
    case (op)
      MD_MULT:  res = $unsigned(sprod);
      MD_MULTU: res = uprod;
      MD_DIV:   res = div_signed($signed(a), $signed(b));
      MD_DIVU:  res = div_unsigned(a, b);
      MD_MADD:  res = acc + $unsigned(sprod);
      MD_MADDU: res = acc + uprod;
      MD_MSUB:  res = acc - $unsigned(sprod);
      MD_MSUBU: res = acc - uprod;
      MD_MTHI:  res = {a, acc[WIDTH-1:0]};
      MD_MTLO:  res = {acc[W2-1:WIDTH], a};
      default:  res = acc;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. The result is computed when the
// op is accepted, held in a pending register, and committed to HI/LO after a
// fixed busy period so the hazard unit sees a deterministic latency.
module md_unit
  import md_defs::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   lat_p0;
  logic [2*WIDTH-1:0] res_p0;
  logic [2*WIDTH-1:0] pend_p1;

  // Stage p0: result formed combinationally from the issuing operands
  md_compute #(
    .WIDTH (WIDTH)
  ) u_compute (
    .op  (md_op),
    .a   (A),
    .b   (B),
    .acc ({hi, lo}),
    .res (res_p0)
  );

  // Busy period for the op being issued
  always_comb begin
    lat_p0 = is_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  end

  // Stage p1: accept/hold/commit FSM; pending result retires into HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pend_p1 <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_multi(md_op)) begin
              pend_p1 <= res_p0;
              cnt     <= lat_p0;
              busy    <= 1'b1;
              state   <= ST_RUN;
            end else if ((md_op == MD_MTHI) || (md_op == MD_MTLO)) begin
              {hi, lo} <= res_p0;
            end
          end
        end
        ST_RUN: begin
          if (cnt == CNT_W'(1)) begin
            {hi, lo} <= pend_p1;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// checked against a 64-bit arithmetic reference model.
module tb_md_unit;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   md_op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] mhl;

  md_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] sp, up, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    up = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0: return sp;
      4'd1: return up;
      4'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        uq = {32'b0, a} / {32'b0, b};
        ur = {32'b0, a} % {32'b0, b};
        return {ur[31:0], uq[31:0]};
      end
      4'd4: return acc + sp;
      4'd5: return acc + up;
      4'd6: return acc - sp;
      4'd7: return acc - up;
      4'd8: return {a, acc[31:0]};
      4'd9: return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'd2 || op == 4'd3) return DL;
    if (op <= 4'd7) return ML;
    return 0;
  endfunction

  // Present one start pulse; returns at the negedge of the first cycle after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; md_op = 4'd15; A = $urandom; B = $urandom;
  endtask

  // Bounded wait for done; cyc counts cycles since acceptance (1 = first busy cycle).
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mhl = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; md_op = 4'd0; A = 32'h5; B = 32'h7;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h, required 0 0", hi, lo);
    end
    reset = 1'b0; start = 1'b0;
    mhl = '0;
  endtask

  task automatic test_mult();
    do_reset();
    issue(4'd0, 32'hFFFFFFFE, 32'd3);
    for (int k = 1; k <= ML; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
        errors++;
        $display("FAIL mult_run cycle %0d: busy=%b done=%b hi=%h lo=%h, required 1 0 0 0",
                 k, busy, done, hi, lo);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL mult_done: busy=%b done=%b, required 0 1", busy, done);
    end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin
      errors++;
      $display("FAIL mult_result: hi:lo=%h, required ffffffff_fffffffa", {hi, lo});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mult_done_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_multu_madd();
    int cyc; bit ok;
    issue(4'd1, 32'hFFFFFFFF, 32'd2);
    wait_done(cyc, ok);
    checks++;
    if (!ok || {hi, lo} !== 64'h00000001_FFFFFFFE) begin
      errors++;
      $display("FAIL multu: done_seen=%0d hi:lo=%h, required 1 00000001_fffffffe", ok, {hi, lo});
    end
    issue(4'd5, 32'd1, 32'd2);
    wait_done(cyc, ok);
    checks++;
    if (!ok || {hi, lo} !== 64'h00000002_00000000) begin
      errors++;
      $display("FAIL maddu: done_seen=%0d hi:lo=%h, required 1 00000002_00000000", ok, {hi, lo});
    end
  endtask

  task automatic test_div();
    int cyc; bit ok;
    issue(4'd2, -32'sd7, 32'd2);
    wait_done(cyc, ok);
    checks++;
    if (!ok || cyc != DL + 1) begin
      errors++;
      $display("FAIL div_latency: done_seen=%0d cycle=%0d, required 1 %0d", ok, cyc, DL + 1);
    end
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL div_neg: hi:lo=%h, required ffffffff_fffffffd", {hi, lo});
    end
    issue(4'd3, 32'd7, 32'd0);
    wait_done(cyc, ok);
    checks++;
    if (!ok || cyc != DL + 1 || {hi, lo} !== 64'h00000007_FFFFFFFF) begin
      errors++;
      $display("FAIL divu_zero: cycle=%0d hi:lo=%h, required %0d 00000007_ffffffff",
               cyc, {hi, lo}, DL + 1);
    end
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, ok);
    checks++;
    if (!ok || {hi, lo} !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL div_ovf: done_seen=%0d hi:lo=%h, required 1 00000000_80000000", ok, {hi, lo});
    end
  endtask

  task automatic test_busy_protect();
    int pulses;
    issue(4'd0, 32'd2, 32'd3);
    @(negedge clk);
    start = 1'b1; md_op = 4'd2; A = 32'd9; B = 32'd3;
    @(negedge clk);
    start = 1'b0; md_op = 4'd15;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL busy_protect_pulses: done pulses=%0d, required 1", pulses);
    end
    checks++;
    if ({hi, lo} !== 64'h00000000_00000006) begin
      errors++;
      $display("FAIL busy_protect_result: hi:lo=%h, required 00000000_00000006", {hi, lo});
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok;
    do_reset();
    issue(4'd8, 32'h1234, 32'd0);
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, required 1234 0 0 0", hi, lo, busy, done);
    end
    issue(4'd0, 32'd7, 32'd6);
    wait_done(cyc, ok);
    checks++;
    if (!ok || {hi, lo} !== 64'd42) begin
      errors++;
      $display("FAIL b2b_first: done_seen=%0d hi:lo=%h, required 1 %h", ok, {hi, lo}, 64'd42);
    end
    start = 1'b1; md_op = 4'd1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0; md_op = 4'd15;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || {hi, lo} !== 64'd42) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b hi:lo=%h, required 1 0 %h", busy, done, {hi, lo}, 64'd42);
    end
    wait_done(cyc, ok);
    checks++;
    if (!ok || cyc != ML + 1 || {hi, lo} !== 64'hFFFFFFFE_00000001) begin
      errors++;
      $display("FAIL b2b_second: cycle=%0d hi:lo=%h, required %0d fffffffe_00000001",
               cyc, {hi, lo}, ML + 1);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; int pulses;
    issue(4'd0, 32'd5, 32'd5);
    wait_done(cyc, ok);
    issue(4'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    reset = 1'b0;
    mhl = '0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || {hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_after: done pulses=%0d hi:lo=%h, required 0 0", pulses, {hi, lo});
    end
  endtask

  task automatic test_random();
    int cyc; bit ok;
    logic [3:0] op;
    logic [31:0] a, b;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 20));
        1: a = -32'($urandom_range(1, 20));
        2: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      mhl = model(op, a, b, mhl);
      issue(op, a, b);
      if (lat_of(op) == 0) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== mhl) begin
          errors++;
          $display("FAIL rand_single[%0d] op=%0d: busy=%b done=%b hi:lo=%h, required 0 0 %h",
                   i, op, busy, done, {hi, lo}, mhl);
        end
      end else begin
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc != lat_of(op) + 1 || {hi, lo} !== mhl) begin
          errors++;
          $display("FAIL rand_multi[%0d] op=%0d a=%h b=%h: cycle=%0d hi:lo=%h, required %0d %h",
                   i, op, a, b, cyc, {hi, lo}, lat_of(op) + 1, mhl);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 4'd15; A = '0; B = '0;
    mhl = '0;
    test_reset();
    test_mult();
    test_multu_madd();
    test_div();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the EX stage of the pipelined CPU.
- Extends the single-cycle combinational ALU with multi-cycle operations: signed/unsigned multiply, divide and multiply-accumulate.
- Provides a start/busy/done handshake so the hazard unit can stall MFHI/MFLO and later MD ops.
- Sits beside the ALU. Operands come from the same forwarded rs/rt buses.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, busy cycles for MULT/MULTU/MADD*/MSUB* (>=1).
- DIV_LAT, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled every edge.
- md_op  in  4  operation code (see Behaviour).
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO just updated by a multi-cycle op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- md_op encodings: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO. Codes 10-15 are a no-op, with no state change.
- Reset: busy=0, done=0, hi=0, lo=0, counter=0, pending result cleared.
- Reset asserted mid-operation aborts it. HI/LO are zeroed and done does not pulse.
- States are IDLE and RUN.
- IDLE:
  - start=1 with a multi-cycle op at edge t: compute the 2*WIDTH result from A, B and the current {hi,lo}, latch it into the pending register, load counter=LAT, go to RUN.
  - busy=1 during cycles t+1 .. t+LAT.
- RUN:
  - counter decrements each edge.
  - At the edge ending cycle t+LAT: {hi,lo} <= pending, go to IDLE.
  - done=1 during cycle t+LAT+1 only.
- Total latency: result visible on hi/lo in cycle t+LAT+1. This is the same cycle busy=0 and done=1.
- Multiply: MULT is signed and MULTU unsigned. {hi,lo} = A*B as full 2*WIDTH product.
- Accumulate: MADD/MADDU = {hi,lo} + product. MSUB/MSUBU = {hi,lo} - product. Arithmetic is modulo 2^(2*WIDTH), with no overflow flag.
- Divide: lo = quotient, truncated toward zero. hi = remainder, with the sign of the dividend (A).
- Divide by zero (B=0): lo = all ones, hi = A. Full latency still applies.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
- MTHI/MTLO in IDLE with start=1: hi (or lo) <= A at that edge. busy and done stay 0.
- start=1 while busy=1 is ignored (no restart, no queueing). Stalling is the hazard unit's responsibility.
- start=1 with a no-op code leaves state unchanged.
- done and a new start in the same cycle is legal: a new op is accepted in cycle t+LAT+1.
- hi/lo keep their old value throughout RUN. MFHI/MFLO must stall on busy.

Decomposition:
- Shared package md_defs holds:
  - md_op localparams (MD_MULT .. MD_MTLO).
  - state encoding (ST_IDLE, ST_RUN).
  - DIV-by-zero constant.
- One natural sub-module: md_compute, combinational. It maps A, B, {hi,lo} and md_op to the 2*WIDTH result, including the signed/unsigned and special-case handling.
- The top-level holds the FSM, counter, pending register and HI/LO.

Test Plan:
- Signed multiply: reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy for 5 cycles; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 for 1 cycle.
- Unsigned multiply and accumulate:
  - MULTU A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
  - Then MADDU A=1, B=2 -> hi=0x00000002, lo=0x00000000.
- Divide:
  - DIV A=-7, B=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
  - DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy protection: start MULT 2*3; at busy cycle 2 issue DIV 9/3 -> ignored; final lo=6, hi=0, single done pulse.
- Back-to-back ops: MTHI A=0x1234 -> hi=0x1234 next cycle, busy stays 0. Start a new MULT in the same cycle done=1 -> accepted, busy rises next cycle.
- Reset mid-op: start DIV, assert reset at busy cycle 4 -> next cycle busy=0, hi=lo=0, no done pulse afterwards.
